bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Shares one combinational 8-bit binary-to-BCD converter (`bin2bcd`) between two requesters in the reaction-time game: requester 0 is the live reaction-time value and requester 1 is the best-score value. The block arbitrates round-robin and registers the selected operand into the converter. It then registers the two-digit result, saturates values above 99, and returns a one-cycle acknowledge to the winner. It sits between the game FSM/score registers and the seven-segment display driver.

## Interface
- No parameters; width fixed at 8-bit operand, 2 BCD digits.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 conversion request (level)
- bin0  in  8  requester 0 operand, unsigned
- req1  in  1  requester 1 conversion request (level)
- bin1  in  8  requester 1 operand, unsigned
- ack0  out  1  one-cycle pulse: requester 0 result valid on tens/ones/ovf
- ack1  out  1  one-cycle pulse: requester 1 result valid on tens/ones/ovf
- tens  out  4  BCD tens digit of last result, 0..9
- ones  out  4  BCD ones digit of last result, 0..9
- ovf  out  1  last operand exceeded 99 (result clamped to 99)
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, CONV, DONE. Reset state: IDLE.
- IDLE:
  - Sample req0/req1.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie after reset.
  - On grant: latch the selected bin into the internal operand register, record the grant id, update the last-grant pointer, and go to CONV.
- CONV:
  - The operand register drives the converter input.
  - If operand > 99: register tens=9, ones=9, ovf=1.
  - Otherwise: register the converter tens/ones and set ovf=0.
  - Go to DONE.
- DONE:
  - Assert ack of the granted id for exactly this cycle, then go to IDLE.
- Requester contract: hold req high and bin stable until its ack. bin is sampled only in the IDLE grant cycle, so later changes do not affect an in-flight conversion.
- Dropping req after the grant does not abort the conversion; the ack is still issued.
- req still high in the IDLE cycle after ack is a new request, arbitrated normally. With both requesters held high, grants alternate 0,1,0,1.
- ack0 and ack1 are never high in the same cycle.
- tens/ones/ovf hold their value until the next CONV→DONE edge.
- Reset mid-operation forces IDLE immediately. The in-flight request is discarded with no ack, and all outputs take their reset values.

## Timing
- Reset values:
  - ack0=0, ack1=0
  - tens=0, ones=0, ovf=0
  - busy=0
  - operand register=0
  - last-grant pointer=1
- Latency: req seen high at IDLE edge N → CONV during cycle N+1 → DONE/ack during cycle N+2. tens/ones/ovf are valid from cycle N+2 onward.
- busy is high in cycles N+1 and N+2.
- Throughput: one conversion per 3 cycles at most. The earliest next grant is the IDLE cycle following DONE.
- busy and ack are registered outputs (decoded from state flops), with no combinational path from req or bin.
- The converter path (operand register → converter → clamp mux → result registers) must close in one cycle.

## Test plan
- Reset/idle: assert rst_n=0 with random inputs, then release with req0=req1=0 for 10 cycles → all outputs 0 and busy=0 throughout.
- Single request: req0=1, bin0=8'd47 → ack0 pulses exactly 2 cycles after the sampling edge with tens=4, ones=7, ovf=0. ack1 stays 0 and busy is high for 2 cycles.
- Saturation and edges:
  - bin1=0 → tens=0, ones=0, ovf=0.
  - bin1=99 → 9/9, ovf=0.
  - bin1=100 → 9/9, ovf=1.
  - bin1=255 → 9/9, ovf=1.
  - Each result arrives with ack1.
- Contention: req0=req1=1 held for 4 conversions with bin0=12, bin1=34 → ack order 0,1,0,1 every 3 cycles. Results alternate 1/2 and 3/4, and ack0 and ack1 never overlap.
- Operand stability and withdrawal: bin0=30 granted; then change bin0 to 80 and drop req0 during CONV → ack0 still pulses with tens=3, ones=0, and no further grant follows.
- Reset mid-operation: grant req1 (bin1=56), then pull rst_n low during CONV for 1 cycle → no ack1, outputs 0, state IDLE. With req1 still high after release, a fresh conversion yields 5/6.

Source files
------------

// File: rtl/bcd_conv_if.sv
// Request/result bundle between the reaction-time game requesters and the
// shared BCD converter arbiter.
interface bcd_conv_if;
    logic       req0;
    logic [7:0] bin0;
    logic       req1;
    logic [7:0] bin1;
    logic       ack0;
    logic       ack1;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    logic       busy;

    modport master (
        output req0, bin0, req1, bin1,
        input  ack0, ack1, tens, ones, ovf, busy
    );

    modport slave (
        input  req0, bin0, req1, bin1,
        output ack0, ack1, tens, ones, ovf, busy
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one 8-bit binary-to-BCD converter between the
// live reaction time (requester 0) and the best score (requester 1).
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operand on the same edge
// CONV  | operand register drives converter; result registers load on exit
// DONE  | one-cycle ack to the granted requester
module bcd_conv_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    bcd_conv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic       grant_sel;
    logic       gnt_id;
    logic       last_gnt;
    logic [7:0] operand;
    logic [7:0] bcd;
    logic [3:0] tens_nxt;
    logic [3:0] ones_nxt;
    logic       ovf_nxt;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       ovf_q;

    // Shift-add-3 conversion; only the low two digits are needed because
    // anything above 99 is clamped downstream.
    function automatic logic [7:0] bin2bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5)
                sh[11:8] = sh[11:8] + 4'd3;
            if (sh[15:12] >= 4'd5)
                sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5)
                sh[19:16] = sh[19:16] + 4'd3;
            sh = {sh[18:0], 1'b0};
        end
        return sh[15:8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant     = 1'b1;
                    grant_sel = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
                    state_nxt = CONV;
                end
            end
            CONV:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd      = bin2bcd(operand);
        tens_nxt = bcd[7:4];
        ones_nxt = bcd[3:0];
        ovf_nxt  = 1'b0;
        if (operand > 8'd99) begin
            tens_nxt = 4'd9;
            ones_nxt = 4'd9;
            ovf_nxt  = 1'b1;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand  <= 8'd0;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (grant) begin
                operand  <= grant_sel ? bus.bin1 : bus.bin0;
                gnt_id   <= grant_sel;
                last_gnt <= grant_sel;
            end
            if (state == CONV) begin
                tens_q <= tens_nxt;
                ones_q <= ones_nxt;
                ovf_q  <= ovf_nxt;
            end
        end
    end

    assign bus.ack0 = (state == DONE) && !gnt_id;
    assign bus.ack1 = (state == DONE) &&  gnt_id;
    assign bus.busy = (state != IDLE);
    assign bus.tens = tens_q;
    assign bus.ones = ones_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: reset, single request, saturation,
// round-robin contention, withdrawal and mid-operation reset.
module tb_bcd_conv_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bcd_conv_if bus ();

    bcd_conv_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req0 = 1'($urandom_range(0, 1));
        bus.req1 = 1'($urandom_range(0, 1));
        bus.bin0 = 8'($urandom_range(0, 255));
        bus.bin1 = 8'($urandom_range(0, 255));
        repeat (3) tick();
        total++;
        if ({bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy} !== 12'd0) begin
            bad++;
            $display("FAIL reset_hold: got ack0=%b ack1=%b tens=%0d ones=%0d ovf=%b busy=%b want all 0",
                     bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy} !== 12'd0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got ack0=%b ack1=%b tens=%0d ones=%0d ovf=%b busy=%b want all 0",
                         k, bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        bus.req0 = 1'b1;
        bus.bin0 = 8'd47;
        tick();
        total++;
        if ({bus.busy, bus.ack0, bus.ack1} !== 3'b100) begin
            bad++;
            $display("FAIL single_conv: got busy=%b ack0=%b ack1=%b want 1 0 0", bus.busy, bus.ack0, bus.ack1);
        end
        tick();
        total++;
        if ({bus.busy, bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf} !== {3'b110, 4'd4, 4'd7, 1'b0}) begin
            bad++;
            $display("FAIL single_done: got busy=%b ack0=%b ack1=%b tens=%0d ones=%0d ovf=%b want 1 1 0 4 7 0",
                     bus.busy, bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf);
        end
        bus.req0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin
                bad++;
                $display("FAIL single_after[%0d]: got busy=%b ack0=%b ack1=%b want 0 0 0",
                         k, bus.busy, bus.ack0, bus.ack1);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] vin [4];
        logic [8:0] vexp [4];
        vin[0] = 8'd0;   vexp[0] = {4'd0, 4'd0, 1'b0};
        vin[1] = 8'd99;  vexp[1] = {4'd9, 4'd9, 1'b0};
        vin[2] = 8'd100; vexp[2] = {4'd9, 4'd9, 1'b1};
        vin[3] = 8'd255; vexp[3] = {4'd9, 4'd9, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.req1 = 1'b1;
            bus.bin1 = vin[i];
            tick();
            tick();
            total++;
            if ({bus.ack1, bus.ack0, bus.tens, bus.ones, bus.ovf} !== {2'b10, vexp[i]}) begin
                bad++;
                $display("FAIL sat_%0d: got ack1=%b ack0=%b tens=%0d ones=%0d ovf=%b want 1 0 %0d %0d %b",
                         vin[i], bus.ack1, bus.ack0, bus.tens, bus.ones, bus.ovf,
                         vexp[i][8:5], vexp[i][4:1], vexp[i][0]);
            end
            bus.req1 = 1'b0;
            tick();
            total++;
            if ({bus.busy, bus.ack1} !== 2'b00) begin
                bad++;
                $display("FAIL sat_%0d_idle: got busy=%b ack1=%b want 0 0", vin[i], bus.busy, bus.ack1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       e_ack0;
        logic       e_ack1;
        logic       e_busy;
        logic [7:0] e_dig;
        bus.req0 = 1'b1;
        bus.bin0 = 8'd12;
        bus.req1 = 1'b1;
        bus.bin1 = 8'd34;
        for (int k = 1; k <= 13; k++) begin
            tick();
            e_ack0 = (k == 2) || (k == 8);
            e_ack1 = (k == 5) || (k == 11);
            e_busy = (k <= 12) && ((k % 3) != 0);
            total++;
            if ({bus.ack0, bus.ack1, bus.busy} !== {e_ack0, e_ack1, e_busy}) begin
                bad++;
                $display("FAIL rr_k%0d: got ack0=%b ack1=%b busy=%b want %b %b %b",
                         k, bus.ack0, bus.ack1, bus.busy, e_ack0, e_ack1, e_busy);
            end
            if (k >= 2) begin
                e_dig = ((k >= 5 && k <= 7) || k >= 11) ? 8'h34 : 8'h12;
                total++;
                if ({bus.tens, bus.ones, bus.ovf} !== {e_dig, 1'b0}) begin
                    bad++;
                    $display("FAIL rr_digits_k%0d: got tens=%0d ones=%0d ovf=%b want %0d %0d 0",
                             k, bus.tens, bus.ones, bus.ovf, e_dig[7:4], e_dig[3:0]);
                end
            end
            if (k == 11) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
    endtask

    task automatic test_withdrawal();
        bus.req0 = 1'b1;
        bus.bin0 = 8'd30;
        tick();
        bus.bin0 = 8'd80;
        bus.req0 = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_conv: got busy=%b want 1", bus.busy);
        end
        tick();
        total++;
        if ({bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf} !== {2'b10, 4'd3, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL wd_done: got ack0=%b ack1=%b tens=%0d ones=%0d ovf=%b want 1 0 3 0 0",
                     bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({bus.busy, bus.ack0} !== 2'b00) begin
                bad++;
                $display("FAIL wd_nogrant[%0d]: got busy=%b ack0=%b want 0 0", k, bus.busy, bus.ack0);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.req1 = 1'b1;
        bus.bin1 = 8'd56;
        tick();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL rm_conv: got busy=%b want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy} !== 12'd0) begin
            bad++;
            $display("FAIL rm_async: got ack0=%b ack1=%b tens=%0d ones=%0d ovf=%b busy=%b want all 0",
                     bus.ack0, bus.ack1, bus.tens, bus.ones, bus.ovf, bus.busy);
        end
        tick();
        total++;
        if ({bus.ack1, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL rm_noack: got ack1=%b busy=%b want 0 0", bus.ack1, bus.busy);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({bus.busy, bus.ack1} !== 2'b10) begin
            bad++;
            $display("FAIL rm_regrant: got busy=%b ack1=%b want 1 0", bus.busy, bus.ack1);
        end
        tick();
        total++;
        if ({bus.ack1, bus.ack0, bus.tens, bus.ones, bus.ovf} !== {2'b10, 4'd5, 4'd6, 1'b0}) begin
            bad++;
            $display("FAIL rm_result: got ack1=%b ack0=%b tens=%0d ones=%0d ovf=%b want 1 0 5 6 0",
                     bus.ack1, bus.ack0, bus.tens, bus.ones, bus.ovf);
        end
        bus.req1 = 1'b0;
        tick();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.bin0 = 8'd0;
        bus.bin1 = 8'd0;
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_withdrawal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
